// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - CSR addresses, mstatus layout, write masks and mtvec mode; CSR_COUNTERS_EN adds mcycle/minstret
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LO   = 11;
    localparam int MSTATUS_MPP_HI   = 12;
    localparam logic [1:0] MSTATUS_MPP_M = 2'b11;

    localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0000_0088;
    localparam logic [63:0] MEPC_WMASK    = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [63:0] MTVEC_WMASK   = 64'hFFFF_FFFF_FFFF_FFFD;
    localparam logic [63:0] MTVEC_BASE_MASK = 64'hFFFF_FFFF_FFFF_FFFC;

    typedef enum logic {
        MTVEC_DIRECT   = 1'b0,
        MTVEC_VECTORED = 1'b1
    } mtvec_mode_e;

    // Architectural view of mstatus: MPP hardwired to M-mode, only MIE/MPIE live
    function automatic logic [63:0] mstatus_view(input logic mie, input logic mpie);
        logic [63:0] v;
        v = '0;
        v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = MSTATUS_MPP_M;
        v[MSTATUS_MPIE_BIT] = mpie;
        v[MSTATUS_MIE_BIT]  = mie;
        return v;
    endfunction

    function automatic logic csr_implemented(input logic [11:0] addr);
        logic hit;
        hit = (addr == CSR_MSTATUS) || (addr == CSR_MIE) || (addr == CSR_MTVEC) ||
              (addr == CSR_MSCRATCH) || (addr == CSR_MEPC) || (addr == CSR_MCAUSE) ||
              (addr == CSR_MTVAL);
`ifdef CSR_COUNTERS_EN
        hit = hit || (addr == CSR_MCYCLE) || (addr == CSR_MINSTRET);
`endif
        return hit;
    endfunction

endpackage

// File: rtl/csr_trap_unit.sv
// rtl/csr_trap_unit.sv - combinational trap entry / MRET next-state and redirect target
module csr_trap_unit
    import csr_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            trap_valid,
    input  logic            mret_valid,
    input  logic            cause_irq,
    input  logic [5:0]      cause_code,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    input  logic            mie,
    input  logic            mpie,
    output logic            event_valid,
    output logic            mie_next,
    output logic            mpie_next,
    output logic [XLEN-1:0] mepc_next,
    output logic [XLEN-1:0] redirect_pc_next
);

    logic [XLEN-1:0] base;
    mtvec_mode_e     mode;

    assign base = mtvec & XLEN'(MTVEC_BASE_MASK);
    assign mode = mtvec_mode_e'(mtvec[0]);

    // Trap beats MRET; mepc/mstatus inputs are already the post-WB-write values
    always_comb begin
        event_valid      = trap_valid | mret_valid;
        mie_next         = mie;
        mpie_next        = mpie;
        mepc_next        = mepc;
        redirect_pc_next = '0;
        if (trap_valid) begin
            mie_next  = 1'b0;
            mpie_next = mie;
            mepc_next = trap_pc & XLEN'(MEPC_WMASK);
            if (mode == MTVEC_VECTORED && cause_irq) begin
                redirect_pc_next = base + XLEN'({cause_code, 2'b00});
            end else begin
                redirect_pc_next = base;
            end
        end else if (mret_valid) begin
            mie_next         = mpie;
            mpie_next        = 1'b1;
            redirect_pc_next = mepc;
        end
    end

endmodule

// File: rtl/csr_regfile.sv
// rtl/csr_regfile.sv - machine-mode CSR storage, bypassed read port, trap/MRET redirect; CSR_COUNTERS_EN adds mcycle/minstret
module csr_regfile
    import csr_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [11:0]     rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic            rd_illegal,
    input  logic            wb_we,
    input  logic [11:0]     wb_addr,
    input  logic [XLEN-1:0] wb_wdata,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret_valid,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
`ifdef CSR_COUNTERS_EN
    input  logic            instret_inc,
`endif
    output logic            mstatus_mie
);

    logic            mstatus_mie_q, mstatus_mie_d;
    logic            mstatus_mpie_q, mstatus_mpie_d;
    logic [XLEN-1:0] csr_mie_q, csr_mie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
`ifdef CSR_COUNTERS_EN
    logic [XLEN-1:0] mcycle_q, mcycle_d;
    logic [XLEN-1:0] minstret_q, minstret_d;
`endif

    logic            wb_commit;
    logic [XLEN-1:0] wb_masked;
    logic            st_mie_w, st_mpie_w;
    logic [XLEN-1:0] mepc_w, mcause_w, mtval_w;
    logic            rd_bypass;

    logic            tu_event, tu_mie, tu_mpie;
    logic [XLEN-1:0] tu_mepc, tu_redirect_pc;

    // A trapping instruction never commits its own CSR write
    assign wb_commit = wb_we & ~trap_valid;

    // Apply per-CSR write masks to WB data; shared by the bypass and the commit
    always_comb begin
        wb_masked = wb_wdata;
        case (wb_addr)
            CSR_MSTATUS: wb_masked = XLEN'(mstatus_view(wb_wdata[MSTATUS_MIE_BIT],
                                                        wb_wdata[MSTATUS_MPIE_BIT]));
            CSR_MEPC:    wb_masked = wb_wdata & XLEN'(MEPC_WMASK);
            CSR_MTVEC:   wb_masked = wb_wdata & XLEN'(MTVEC_WMASK);
            default:     ;
        endcase
    end

    // WB commit stage: post-write values that trap/MRET sequencing then builds on
    always_comb begin
        csr_mie_d  = csr_mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_w     = mepc_q;
        mcause_w   = mcause_q;
        mtval_w    = mtval_q;
        st_mie_w   = mstatus_mie_q;
        st_mpie_w  = mstatus_mpie_q;
`ifdef CSR_COUNTERS_EN
        mcycle_d   = mcycle_q + XLEN'(1);
        minstret_d = minstret_q + XLEN'(instret_inc);
`endif
        if (wb_commit) begin
            case (wb_addr)
                CSR_MSTATUS: begin
                    st_mie_w  = wb_wdata[MSTATUS_MIE_BIT];
                    st_mpie_w = wb_wdata[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:      csr_mie_d  = wb_masked;
                CSR_MTVEC:    mtvec_d    = wb_masked;
                CSR_MSCRATCH: mscratch_d = wb_masked;
                CSR_MEPC:     mepc_w     = wb_masked;
                CSR_MCAUSE:   mcause_w   = wb_masked;
                CSR_MTVAL:    mtval_w    = wb_masked;
`ifdef CSR_COUNTERS_EN
                CSR_MCYCLE:   mcycle_d   = wb_masked;
                CSR_MINSTRET: minstret_d = wb_masked;
`endif
                default:      ;
            endcase
        end
    end

    csr_trap_unit #(.XLEN(XLEN)) u_trap (
        .trap_valid       (trap_valid),
        .mret_valid       (mret_valid),
        .cause_irq        (trap_cause[XLEN-1]),
        .cause_code       (trap_cause[5:0]),
        .trap_pc          (trap_pc),
        .mtvec            (mtvec_q),
        .mepc             (mepc_w),
        .mie              (st_mie_w),
        .mpie             (st_mpie_w),
        .event_valid      (tu_event),
        .mie_next         (tu_mie),
        .mpie_next        (tu_mpie),
        .mepc_next        (tu_mepc),
        .redirect_pc_next (tu_redirect_pc)
    );

    // Event stage: fold trap/MRET results over the committed values
    always_comb begin
        mstatus_mie_d    = tu_mie;
        mstatus_mpie_d   = tu_mpie;
        mepc_d           = tu_mepc;
        mcause_d         = trap_valid ? trap_cause : mcause_w;
        mtval_d          = trap_valid ? trap_tval  : mtval_w;
        redirect_valid_d = tu_event;
        redirect_pc_d    = tu_event ? tu_redirect_pc : redirect_pc_q;
    end

    // CSR state and the redirect pulse; reset also kills a pending redirect
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mstatus_mie_q    <= 1'b0;
            mstatus_mpie_q   <= 1'b0;
            csr_mie_q        <= '0;
            mtvec_q          <= RESET_MTVEC;
            mscratch_q       <= '0;
            mepc_q           <= '0;
            mcause_q         <= '0;
            mtval_q          <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
`ifdef CSR_COUNTERS_EN
            mcycle_q         <= '0;
            minstret_q       <= '0;
`endif
        end else begin
            mstatus_mie_q    <= mstatus_mie_d;
            mstatus_mpie_q   <= mstatus_mpie_d;
            csr_mie_q        <= csr_mie_d;
            mtvec_q          <= mtvec_d;
            mscratch_q       <= mscratch_d;
            mepc_q           <= mepc_d;
            mcause_q         <= mcause_d;
            mtval_q          <= mtval_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
`ifdef CSR_COUNTERS_EN
            mcycle_q         <= mcycle_d;
            minstret_q       <= minstret_d;
`endif
        end
    end

    // Read port: register view, overridden by the masked WB value on an address match
    always_comb begin
        rd_illegal = ~csr_implemented(rd_addr);
        rd_bypass  = wb_we & ~trap_valid & ~mret_valid & (wb_addr == rd_addr) & ~rd_illegal;
        rd_data    = '0;
        case (rd_addr)
            CSR_MSTATUS:  rd_data = XLEN'(mstatus_view(mstatus_mie_q, mstatus_mpie_q));
            CSR_MIE:      rd_data = csr_mie_q;
            CSR_MTVEC:    rd_data = mtvec_q;
            CSR_MSCRATCH: rd_data = mscratch_q;
            CSR_MEPC:     rd_data = mepc_q;
            CSR_MCAUSE:   rd_data = mcause_q;
            CSR_MTVAL:    rd_data = mtval_q;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE:   rd_data = mcycle_q;
            CSR_MINSTRET: rd_data = minstret_q;
`endif
            default:      rd_data = '0;
        endcase
        if (rd_bypass) begin
            rd_data = wb_masked;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign mstatus_mie    = mstatus_mie_q;

endmodule

// File: tb/tb_csr_regfile.sv
// tb/tb_csr_regfile.sv - randomized self-checking bench for csr_regfile against a map-based CSR model
module tb_csr_regfile;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [11:0] rd_addr = '0;
    logic [63:0] rd_data;
    logic        rd_illegal;
    logic        wb_we = 1'b0;
    logic [11:0] wb_addr = '0;
    logic [63:0] wb_wdata = '0;
    logic        trap_valid = 1'b0;
    logic [63:0] trap_cause = '0;
    logic [63:0] trap_pc = '0;
    logic [63:0] trap_tval = '0;
    logic        mret_valid = 1'b0;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        instret_inc = 1'b0;
    logic        mstatus_mie;

    localparam logic [63:0] RST_MTVEC = 64'h8000_0000;

    csr_regfile #(.XLEN(64), .RESET_MTVEC(RST_MTVEC)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .rd_illegal     (rd_illegal),
        .wb_we          (wb_we),
        .wb_addr        (wb_addr),
        .wb_wdata       (wb_wdata),
        .trap_valid     (trap_valid),
        .trap_cause     (trap_cause),
        .trap_pc        (trap_pc),
        .trap_tval      (trap_tval),
        .mret_valid     (mret_valid),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
`ifdef CSR_COUNTERS_EN
        .instret_inc    (instret_inc),
`endif
        .mstatus_mie    (mstatus_mie)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b1;

    logic [63:0] m_csr [int];
    logic        m_rv;
    logic [63:0] m_rpc;

    int addr_tab [12] = '{'h300, 'h304, 'h305, 'h340, 'h341, 'h342, 'h343,
                          'hB00, 'hB02, 'h301, 'h000, 'hFFF};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] wmask(input int a, input logic [63:0] d);
        case (a)
            'h300:   return 64'h1800 | (d & 64'h88);
            'h341:   return d - (d % 4);
            'h305:   return d & ~64'h2;
            default: return d;
        endcase
    endfunction

    function automatic logic [63:0] mbit(input int b);
        logic [63:0] v;
        v = m_csr['h300];
        return {63'b0, v[b]};
    endfunction

    task automatic model_reset();
        m_csr.delete();
        m_csr['h300] = 64'h1800;
        m_csr['h304] = 0;
        m_csr['h305] = RST_MTVEC;
        m_csr['h340] = 0;
        m_csr['h341] = 0;
        m_csr['h342] = 0;
        m_csr['h343] = 0;
`ifdef CSR_COUNTERS_EN
        m_csr['hB00] = 0;
        m_csr['hB02] = 0;
`endif
        m_rv  = 1'b0;
        m_rpc = 0;
    endtask

    function automatic logic [63:0] exp_rd();
        int a;
        a = int'(rd_addr);
        if (!m_csr.exists(a)) return 0;
        if (wb_we && !trap_valid && !mret_valid && wb_addr == rd_addr) return wmask(a, wb_wdata);
        return m_csr[a];
    endfunction

    task automatic model_step();
        logic [63:0] st, tv;
        bit wrote_cyc, wrote_ins;
        int wa;
        wa = int'(wb_addr);
        wrote_cyc = 0;
        wrote_ins = 0;
        if (trap_valid) begin
            tv = m_csr['h305];
            m_rpc = tv - (tv % 4);
            if (tv[0] && trap_cause[63]) m_rpc = m_rpc + 4 * (trap_cause % 64);
            m_csr['h341] = trap_pc - (trap_pc % 4);
            m_csr['h342] = trap_cause;
            m_csr['h343] = trap_tval;
            st = m_csr['h300];
            m_csr['h300] = 64'h1800 | (st[3] ? 64'h80 : 64'h0);
            m_rv = 1'b1;
        end else begin
            if (wb_we && m_csr.exists(wa)) begin
                m_csr[wa] = wmask(wa, wb_wdata);
                wrote_cyc = (wa == 'hB00);
                wrote_ins = (wa == 'hB02);
            end
            if (mret_valid) begin
                st = m_csr['h300];
                m_csr['h300] = 64'h1880 | (st[7] ? 64'h8 : 64'h0);
                m_rpc = m_csr['h341];
                m_rv  = 1'b1;
            end else begin
                m_rv = 1'b0;
            end
        end
`ifdef CSR_COUNTERS_EN
        if (!wrote_cyc) m_csr['hB00] = m_csr['hB00] + 1;
        if (!wrote_ins && instret_inc) m_csr['hB02] = m_csr['hB02] + 1;
`endif
    endtask

    always @(posedge clk) if (rstn) model_step();
    always @(negedge rstn) model_reset();

    // Every cycle: DUT outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd_data", rd_data, exp_rd());
            chk("rd_illegal", {63'b0, rd_illegal}, {63'b0, !m_csr.exists(int'(rd_addr))});
            chk("redirect_valid", {63'b0, redirect_valid}, {63'b0, m_rv});
            chk("redirect_pc", redirect_pc, m_rpc);
            chk("mstatus_mie", {63'b0, mstatus_mie}, mbit(3));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_we = 0; trap_valid = 0; mret_valid = 0; instret_inc = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) tick();
        rstn = 1'b1;

        rd_addr = 12'h305;
        @(negedge clk);
        chk("lit_reset_mtvec", exp_rd(), 64'h8000_0000);
        tick();
        rd_addr = 12'h300;
        @(negedge clk);
        chk("lit_reset_mstatus", exp_rd(), 64'h1800);

        tick();
        wb_we = 1; wb_addr = 12'h340; wb_wdata = 64'hDEAD_BEEF; rd_addr = 12'h340;
        @(negedge clk);
        chk("lit_bypass", exp_rd(), 64'hDEAD_BEEF);
        tick();
        idle();
        @(negedge clk);
        chk("lit_mscratch_reg", exp_rd(), 64'hDEAD_BEEF);

        tick();
        wb_we = 1; wb_addr = 12'h300; wb_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        wb_addr = 12'h305; wb_wdata = 64'h1001;
        tick();
        idle();
        trap_valid = 1; trap_cause = 64'h8000_0000_0000_0007; trap_pc = 64'h2006; trap_tval = 64'h99;
        tick();
        idle();
        rd_addr = 12'h341;
        @(negedge clk);
        chk("lit_trap_rv", {63'b0, m_rv}, 64'd1);
        chk("lit_trap_rpc", m_rpc, 64'h101C);
        chk("lit_trap_mepc", exp_rd(), 64'h2004);
        chk("lit_trap_mie", mbit(3), 64'd0);
        chk("lit_trap_mpie", mbit(7), 64'd1);
        tick();
        @(negedge clk);
        chk("lit_pulse_end", {63'b0, m_rv}, 64'd0);
        tick();
        mret_valid = 1;
        tick();
        idle();
        @(negedge clk);
        chk("lit_mret_rv", {63'b0, m_rv}, 64'd1);
        chk("lit_mret_rpc", m_rpc, 64'h2004);
        chk("lit_mret_mie", mbit(3), 64'd1);
        chk("lit_mret_mpie", mbit(7), 64'd1);

        tick();
        trap_valid = 1; trap_cause = 64'h5; trap_pc = 64'h3000; trap_tval = 64'h77;
        wb_we = 1; wb_addr = 12'h340; wb_wdata = 64'h1234;
        tick();
        idle();
        rd_addr = 12'h340;
        @(negedge clk);
        chk("lit_trap_wb_mscratch", exp_rd(), 64'hDEAD_BEEF);
        chk("lit_trap_wb_rpc", m_rpc, 64'h1000);
        tick();
        rd_addr = 12'h342;
        @(negedge clk);
        chk("lit_trap_wb_mcause", exp_rd(), 64'h5);

        tick();
        trap_valid = 1;
        tick();
        idle();
        #2;
        rstn = 1'b0;
        @(negedge clk);
        chk("lit_reset_kills_redirect", {63'b0, m_rv}, 64'd0);
        tick();
        rstn = 1'b1;

`ifdef CSR_COUNTERS_EN
        wb_we = 1; wb_addr = 12'hB00; wb_wdata = 64'hFFFF_FFFF_FFFF_FFFE; rd_addr = 12'hB01;
        tick();
        idle();
        rd_addr = 12'hB00;
        @(negedge clk);
        chk("lit_mcycle_written", exp_rd(), 64'hFFFF_FFFF_FFFF_FFFE);
        tick();
        @(negedge clk);
        chk("lit_mcycle_max", exp_rd(), 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        @(negedge clk);
        chk("lit_mcycle_wrap", exp_rd(), 64'h0);
`else
        rd_addr = 12'hB00;
        @(negedge clk);
        chk("lit_mcycle_absent", {63'b0, !m_csr.exists(int'(rd_addr))}, 64'd1);
`endif

        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 499) == 0) begin
                #2;
                rstn = 1'b0;
                tick();
                rstn = 1'b1;
            end
            rd_addr  = 12'(addr_tab[$urandom_range(0, 11)]);
            wb_we    = ($urandom_range(0, 1) == 1);
            wb_addr  = ($urandom_range(0, 2) == 0) ? rd_addr : 12'(addr_tab[$urandom_range(0, 11)]);
            wb_wdata = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) wb_wdata = {$urandom_range(0, 1) == 1 ? 32'hFFFF_FFFF : 32'h0, 24'h0, 8'($urandom)};
            trap_valid  = ($urandom_range(0, 7) == 0);
            mret_valid  = ($urandom_range(0, 7) == 0);
            instret_inc = ($urandom_range(0, 1) == 1);
            trap_cause  = {$urandom_range(0, 1) == 1, 57'($urandom), 6'($urandom)};
            trap_pc     = {$urandom, $urandom};
            trap_tval   = {$urandom, $urandom};
        end
        tick();
        idle();
        @(negedge clk);
        @(posedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_regfile.md
Name: csr_regfile

Overview:
Machine-mode CSR storage for the 5-stage RV64 core. Sits on both sides of the EX-stage CSR ALU:
- Supplies the old CSR value (EX_csr_val) through a combinational read port.
- Commits the ALU-produced new value from the WB stage.
- Owns trap entry and MRET sequencing, and issues a registered PC redirect to the fetch stage.

Parameters:
XLEN, 64, data width of every CSR and of the PC.
RESET_MTVEC, 64'h0, reset value of mtvec.

Ports:
clk  in  1  core clock; all state updates on rising edge.
rstn  in  1  asynchronous, active-low reset.
rd_addr  in  12  CSR address decoded in ID/EX.
rd_data  out  XLEN  old CSR value (combinational, bypassed); drives EX_csr_val.
rd_illegal  out  1  rd_addr is not implemented (combinational).
wb_we  in  1  commit a CSR write this cycle.
wb_addr  in  12  WB-stage CSR address.
wb_wdata  in  XLEN  WB-stage CSR ALU result.
trap_valid  in  1  exception or interrupt taken at WB.
trap_cause  in  XLEN  mcause value; bit63 = interrupt.
trap_pc  in  XLEN  PC of the faulting instruction.
trap_tval  in  XLEN  mtval value.
mret_valid  in  1  MRET retiring at WB.
redirect_valid  out  1  registered one-cycle pulse.
redirect_pc  out  XLEN  registered redirect target.
mstatus_mie  out  1  global interrupt enable, for the interrupt controller.

Behaviour:
Implemented CSRs: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343.
- Any other address: rd_data = 0 and rd_illegal = 1. A write to an unimplemented address is dropped.

Reset values:
- All CSRs are 0, except mtvec = RESET_MTVEC and mstatus.MPP = 2'b11.
- redirect_valid = 0, redirect_pc = 0.

Write masks:
- mstatus: only MIE[3] and MPIE[7] are writable. MPP[12:11] reads 2'b11. All other bits read 0.
- mepc: bits[1:0] are forced to 0.
- mtvec: bit1 is forced to 0; mode is bit0 (0 = direct, 1 = vectored).
- mie, mscratch, mcause, mtval: full width writable.

Read port:
- rd_data is combinational from the registers.
- Bypass: if wb_we && wb_addr == rd_addr && !trap_valid && !mret_valid, rd_data = wb_wdata after the write mask is applied.
- Bypass also applies when rd_addr is 0x300, returning the masked mstatus view.

Write port:
- The write lands on the clock edge in which wb_we = 1. It is visible in registers the next cycle.

Trap entry (trap_valid = 1), all in one edge:
- mepc <= {trap_pc[63:2], 2'b00}
- mcause <= trap_cause
- mtval <= trap_tval
- MPIE <= MIE, MIE <= 0
- redirect_valid <= 1
- redirect_pc <= target, where target is:
  - {mtvec[63:2], 2'b00} in direct mode, or for any exception;
  - base + 4*trap_cause[5:0] when mtvec bit0 = 1 and trap_cause[63] = 1.

MRET (mret_valid = 1, trap_valid = 0):
- MIE <= MPIE, MPIE <= 1
- redirect_valid <= 1
- redirect_pc <= mepc, using the current register value, including a same-cycle wb write to mepc, which is taken first.

Simultaneous events:
- trap_valid has priority over mret_valid and suppresses the wb write (the writing instruction is the one trapping).
- mret_valid together with wb_we: the wb write commits first, and MRET reads the post-write mstatus/mepc.

Redirect pulse:
- redirect_valid is high for exactly one cycle after the event. It returns to 0 the next cycle unless another event occurs.

Reset mid-operation:
- Asserting rstn low clears state immediately (asynchronous), including a pending redirect.

Optional Feature:
Macro CSR_COUNTERS_EN.
- Defined: adds mcycle 0xB00 and minstret 0xB02, 64-bit, reset 0.
  - mcycle increments every cycle.
  - minstret increments when input instret_inc = 1 (port present only with the macro).
  - A wb write to a counter wins over the increment in that cycle; counting resumes from the written value.
  - Both counters wrap from 2^64-1 to 0.
- Undefined: both addresses are unimplemented (rd_illegal = 1) and instret_inc is absent.

Decomposition:
Package csr_pkg holds:
- CSR address localparams.
- mstatus bit-position constants (MIE = 3, MPIE = 7, MPP = 12:11).
- Write-mask constants.
- mtvec mode enum.

One sub-module, csr_trap_unit: combinational computation of trap/MRET next-state values and redirect target. The register storage stays in csr_regfile.

Test Plan:
- Reset release with RESET_MTVEC = 64'h8000_0000 -> read 0x305 gives 64'h8000_0000; read 0x300 gives 64'h1800.
- wb write 0x340 = 64'hDEAD_BEEF with rd_addr = 0x340 in the same cycle -> rd_data = 64'hDEAD_BEEF that cycle via bypass, and the same value from the register next cycle.
- mtvec = 64'h1001, trap with cause 64'h8000_0000_0000_0007 and pc 64'h2006 -> next cycle: redirect_valid = 1 for one cycle, redirect_pc = 64'h101C, mepc = 64'h2004, MIE = 0.
- MIE = 1, trap, then mret -> after trap MPIE = 1, MIE = 0; after mret MIE = 1, MPIE = 1, redirect_pc = mepc.
- trap_valid and wb_we to 0x340 in the same cycle -> mscratch unchanged, trap state updated.
- With CSR_COUNTERS_EN: write mcycle = 64'hFFFF_FFFF_FFFF_FFFE -> reads 0xFFFF_FFFF_FFFF_FFFF, then 0, on successive cycles. Without the macro: read 0xB00 gives rd_illegal = 1.
